// File: rtl/norm_sequencer.sv
// Mantissa normalizer: one left shift per cycle, or one right shift on carry, with exponent adjustment.
// Optional sticky bit tracking is built only when NORM_STICKY_EN is defined.
module norm_sequencer #(
  parameter int N_mant = 25,
  parameter int N_exp  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_mant-1:0] mantissa_in,
  input  logic [N_exp-1:0]  expoente_in,
  output logic              busy,
  output logic              done,
  output logic [N_mant-2:0] mantissa_out,
  output logic [N_exp-1:0]  expoente_out,
  output logic              sticky,
  output logic              zero,
  output logic              underflow,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N_exp-1:0] EXP_ONE = N_exp'(1);
  localparam logic [N_exp-1:0] EXP_MAX = '1;

  state_t            state;
  logic [N_mant-1:0] mant_q;
  logic [N_exp-1:0]  exp_q;
  logic [N_exp-1:0]  exp_inc;
  logic [N_exp-1:0]  exp_dec;
  logic              mant_zero;
  logic              carry_bit;
  logic              hidden_bit;

  assign exp_inc    = exp_q + EXP_ONE;
  assign exp_dec    = exp_q - EXP_ONE;
  assign mant_zero  = (mant_q == '0);
  assign carry_bit  = mant_q[N_mant-1];
  assign hidden_bit = mant_q[N_mant-2];

  assign mantissa_out = mant_q[N_mant-2:0];
  assign expoente_out = exp_q;

  // RUN resolves exactly one case per cycle: zero, carry, normalized, underflow, then left shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mant_q    <= '0;
      exp_q     <= '0;
      zero      <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mant_q    <= mantissa_in;
            exp_q     <= expoente_in;
            zero      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (mant_zero) begin
            zero  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (carry_bit) begin
            mant_q   <= mant_q >> 1;
            exp_q    <= exp_inc;
            overflow <= (exp_inc == EXP_MAX);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (hidden_bit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (exp_q == '0) begin
            underflow <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            mant_q <= {mant_q[N_mant-2:0], 1'b0};
            exp_q  <= exp_dec;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NORM_STICKY_EN
  logic sticky_q;

  // Only the carry right shift can push a bit off the bottom of the mantissa.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (state == IDLE && start) begin
      sticky_q <= 1'b0;
    end else if (state == RUN && !mant_zero && carry_bit) begin
      sticky_q <= sticky_q | mant_q[0];
    end
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_norm_sequencer.sv
// Self-checking bench for norm_sequencer: directed corner cases plus random operands
// compared against a leading-one based reference model.
module tb_norm_sequencer;

  localparam int NM = 25;
  localparam int NE = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NM-1:0] mantissa_in;
  logic [NE-1:0] expoente_in;
  logic          busy;
  logic          done;
  logic [NM-2:0] mantissa_out;
  logic [NE-1:0] expoente_out;
  logic          sticky;
  logic          zero;
  logic          underflow;
  logic          overflow;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  norm_sequencer #(.N_mant(NM), .N_exp(NE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mantissa_in  (mantissa_in),
    .expoente_in  (expoente_in),
    .busy         (busy),
    .done         (done),
    .mantissa_out (mantissa_out),
    .expoente_out (expoente_out),
    .sticky       (sticky),
    .zero         (zero),
    .underflow    (underflow),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: locate the leading one and compute the whole result in one step.
  task automatic model(input logic [NM-1:0] m, input logic [NE-1:0] e,
                       output logic [NM-2:0] em, output logic [NE-1:0] ee,
                       output logic es, output logic ez, output logic eu, output logic eo,
                       output int lat);
    logic [NM-1:0] t;
    int p, k;
    t = m; ee = e; es = 1'b0; ez = 1'b0; eu = 1'b0; eo = 1'b0; lat = 2;
    if (m == '0) begin
      ez = 1'b1;
    end else if (m[NM-1]) begin
      t  = m >> 1;
      ee = NE'(int'(e) + 1);
      eo = (ee == {NE{1'b1}});
`ifdef NORM_STICKY_EN
      es = m[0];
`endif
    end else begin
      p = 0;
      for (int i = 0; i < NM-1; i++) if (m[i]) p = i;
      k = (NM-2) - p;
      if (k <= int'(e)) begin
        t   = m << k;
        ee  = NE'(int'(e) - k);
        lat = 2 + k;
      end else begin
        t   = m << e;
        ee  = '0;
        eu  = 1'b1;
        lat = 2 + int'(e);
      end
    end
    em = t[NM-2:0];
  endtask

  task automatic applyStimulus(input logic [NM-1:0] m, input logic [NE-1:0] e, input string name);
    logic [NM-2:0] em;
    logic [NE-1:0] ee;
    logic es, ez, eu, eo;
    int lat, cyc, done_cyc;
    model(m, e, em, ee, es, ez, eu, eo, lat);
    mantissa_in = m;
    expoente_in = e;
    start       = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    checkOutput({name, ".busy"}, 32'(busy), 32'd1);
    done_cyc = 0;
    while (done_cyc == 0 && cyc < 60) begin
      if (done) begin
        done_cyc = cyc;
      end else begin
        // Junk requests while busy must be ignored.
        start       = 1'($urandom_range(0, 1));
        mantissa_in = NM'($urandom);
        expoente_in = NE'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    checkOutput({name, ".latency"},   32'(done_cyc),     32'(lat));
    checkOutput({name, ".mantissa"},  32'(mantissa_out), 32'(em));
    checkOutput({name, ".expoente"},  32'(expoente_out), 32'(ee));
    checkOutput({name, ".sticky"},    32'(sticky),       32'(es));
    checkOutput({name, ".zero"},      32'(zero),         32'(ez));
    checkOutput({name, ".underflow"}, 32'(underflow),    32'(eu));
    checkOutput({name, ".overflow"},  32'(overflow),     32'(eo));
    checkOutput({name, ".busy_done"}, 32'(busy),         32'd0);
    @(posedge clk); #1;
    checkOutput({name, ".done_pulse"}, 32'(done),         32'd0);
    checkOutput({name, ".hold"},       32'(mantissa_out), 32'(em));
  endtask

  initial begin
    logic saw_done;
    logic [NM-1:0] m;
    logic [NE-1:0] e;
    rst = 1'b1; start = 1'b0; mantissa_in = '0; expoente_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.outs", 32'({mantissa_out, expoente_out, sticky, zero, underflow, overflow}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(25'h0800000, 8'h80, "normalized");
    applyStimulus(25'h1000001, 8'h7F, "carry");
    applyStimulus(25'h0000001, 8'h80, "max_left");
    applyStimulus(25'h0000100, 8'h03, "underflow");
    applyStimulus(25'h1800000, 8'hFE, "overflow");
    applyStimulus(25'h0000000, 8'h55, "zero");
    applyStimulus(25'h1000000, 8'hFF, "exp_wrap");
    applyStimulus(25'h0400000, 8'h00, "uf_at_zero");

    // Abort a long normalization with reset on its fourth edge.
    mantissa_in = 25'h0000001; expoente_in = 8'h80; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_done = saw_done | done;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    saw_done = saw_done | done;
    checkOutput("abort.no_done", 32'(saw_done), 32'd0);
    checkOutput("abort.busy",    32'(busy),     32'd0);
    checkOutput("abort.outs", 32'({mantissa_out, expoente_out, sticky, zero, underflow, overflow}), 32'd0);
    rst = 1'b0;
    applyStimulus(25'h0800000, 8'h80, "after_abort");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: m = NM'($urandom);
        1: m = NM'($urandom) >> $urandom_range(0, NM-1);
        2: m = NM'($urandom) | {1'b1, {(NM-1){1'b0}}};
        3: m = '0;
        default: m = NM'(1) << $urandom_range(0, NM-2);
      endcase
      e = ($urandom_range(0, 2) == 0) ? NE'($urandom_range(0, 20)) : NE'($urandom);
      applyStimulus(m, e, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
